reaction_test_ctrl: RTL and testbench

Sequencing controller for the reaction-speed tester. It arms a trial on a button press and waits a pseudo-random delay. It then enables the 4-digit BCD millisecond counter and latches the count when the button is pressed again. It also detects false starts and timeouts, and tracks the best time. The block sits between the debounced button, the 1 ms tick generator and the BCD counter, and it drives the display mux and status LEDs.

---
 rtl/reaction_pkg.sv | 16 +
 rtl/reaction_lfsr.sv | 21 ++
 rtl/reaction_test_ctrl.sv | 121 ++++++++++++
 tb/tb_reaction_test_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-speed tester controller.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        COUNTING = 3'd2,
        DONE     = 3'd3,
        FOUL     = 3'd4,
        TIMEOUT  = 3'd5
    } state_t;

    localparam logic [15:0] BCD_MAX   = 16'h9999;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/reaction_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11) with enable; resets to its seed.
module reaction_lfsr
    import reaction_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
        end
    end

endmodule

// File: rtl/reaction_test_ctrl.sv
// Reaction tester sequencer: arm, random delay, timed count, false start,
// timeout and best-time tracking.
module reaction_test_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned RAND_BITS    = 10,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1ms,
    input  logic        btn,
    input  logic [15:0] count_in,
    output logic        cnt_en,
    output logic        cnt_clr,
    output logic [15:0] result,
    output logic        result_valid,
    output logic [15:0] best,
    output logic        best_valid,
    output logic        foul,
    output logic        timeout,
    output logic [2:0]  state
);

    localparam logic [15:0] RAND_MASK = 16'((32'd1 << RAND_BITS) - 32'd1);

    state_t      state_q;
    state_t      state_d;
    logic        btn_q;
    logic        press;
    logic        enter_armed;
    logic [15:0] lfsr;
    logic [15:0] delay_cnt;
    logic [15:0] delay_load;

    reaction_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .reset(reset),
        .en   (1'b1),
        .lfsr (lfsr)
    );

    assign press       = btn & ~btn_q;
    assign delay_load  = 16'(MIN_DELAY_MS) + (lfsr & RAND_MASK);
    assign enter_armed = (state_d == ARMED) && (state_q != ARMED);
    assign state       = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (press) state_d = ARMED;
            ARMED: begin
                if (press)                               state_d = FOUL;
                else if (tick_1ms && delay_cnt == 16'd1) state_d = COUNTING;
            end
            COUNTING: begin
                if (press)                    state_d = DONE;
                else if (count_in == BCD_MAX) state_d = TIMEOUT;
            end
            DONE, FOUL, TIMEOUT: if (press) state_d = ARMED;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn;
        end
    end

    // Flags and enables key off the transition so they line up with the state edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_en       <= 1'b0;
            cnt_clr      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            best         <= BCD_MAX;
            best_valid   <= 1'b0;
            foul         <= 1'b0;
            timeout      <= 1'b0;
            delay_cnt    <= '0;
        end else begin
            cnt_clr <= enter_armed;
            cnt_en  <= (state_d == COUNTING);

            if (enter_armed) begin
                delay_cnt <= delay_load;
                foul      <= 1'b0;
                timeout   <= 1'b0;
            end else if (state_q == ARMED && tick_1ms) begin
                delay_cnt <= delay_cnt - 16'd1;
            end

            if (state_q == COUNTING && state_d == DONE) begin
                result       <= count_in;
                result_valid <= 1'b1;
                if (!best_valid || count_in < best) begin
                    best       <= count_in;
                    best_valid <= 1'b1;
                end
            end

            if (state_q == ARMED && state_d == FOUL) begin
                foul <= 1'b1;
            end

            if (state_q == COUNTING && state_d == TIMEOUT) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reaction_test_ctrl.sv
// Self-checking bench for reaction_test_ctrl: directed trial table plus
// randomized stimulus against a behavioural reference model.
module tb_reaction_test_ctrl;
    import reaction_pkg::*;

    localparam int unsigned MIN_D = 1000;
    localparam int unsigned RB    = 10;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_1ms;
    logic        btn;
    logic [15:0] count_in;
    logic        cnt_en;
    logic        cnt_clr;
    logic [15:0] result;
    logic        result_valid;
    logic [15:0] best;
    logic        best_valid;
    logic        foul;
    logic        timeout;
    logic [2:0]  state;

    always #5 clk = ~clk;

    reaction_test_ctrl #(
        .MIN_DELAY_MS(MIN_D),
        .RAND_BITS   (RB),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1ms    (tick_1ms),
        .btn         (btn),
        .count_in    (count_in),
        .cnt_en      (cnt_en),
        .cnt_clr     (cnt_clr),
        .result      (result),
        .result_valid(result_valid),
        .best        (best),
        .best_valid  (best_valid),
        .foul        (foul),
        .timeout     (timeout),
        .state       (state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: trial phase plus tick count toward the drawn delay.
    int          m_state;
    int          m_ticks;
    int          m_target;
    bit          m_btn_q;
    logic [15:0] m_lfsr;
    logic [15:0] m_result;
    bit          m_rv;
    logic [15:0] m_best;
    bit          m_bv;
    bit          m_foul;
    bit          m_to;
    bit          m_cnt_en;
    bit          m_cnt_clr;

    function automatic int bcd2int(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        v = {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_ticks = 0; m_target = 0; m_btn_q = 0; m_lfsr = SEED;
        m_result = 16'h0000; m_rv = 0; m_best = 16'h9999; m_bv = 0;
        m_foul = 0; m_to = 0; m_cnt_en = 0; m_cnt_clr = 0;
    endtask

    task automatic model_step();
        bit press;
        int nxt;
        press = btn && !m_btn_q;
        nxt   = m_state;
        case (m_state)
            0: if (press) nxt = 1;
            1: begin
                if (press) nxt = 4;
                else if (tick_1ms) begin
                    m_ticks++;
                    if (m_ticks == m_target) nxt = 2;
                end
            end
            2: begin
                if (press) nxt = 3;
                else if (count_in == 16'h9999) nxt = 5;
            end
            3, 4, 5: if (press) nxt = 1;
            default: nxt = 0;
        endcase
        m_cnt_clr = (nxt == 1 && m_state != 1);
        if (m_cnt_clr) begin
            m_foul = 0; m_to = 0; m_ticks = 0;
            m_target = int'(MIN_D) + int'(m_lfsr) % (1 << RB);
        end
        if (m_state == 2 && nxt == 3) begin
            m_result = count_in; m_rv = 1;
            if (!m_bv || bcd2int(count_in) < bcd2int(m_best)) begin
                m_best = count_in; m_bv = 1;
            end
        end
        if (m_state == 1 && nxt == 4) m_foul = 1;
        if (m_state == 2 && nxt == 5) m_to = 1;
        m_cnt_en = (nxt == 2);
        m_state  = nxt;
        m_btn_q  = btn;
        m_lfsr   = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    endtask

    task automatic check_all();
        chk("state",        16'(state),        16'(m_state));
        chk("cnt_en",       16'(cnt_en),       16'(m_cnt_en));
        chk("cnt_clr",      16'(cnt_clr),      16'(m_cnt_clr));
        chk("result",       result,            m_result);
        chk("result_valid", 16'(result_valid), 16'(m_rv));
        chk("best",         best,              m_best);
        chk("best_valid",   16'(best_valid),   16'(m_bv));
        chk("foul",         16'(foul),         16'(m_foul));
        chk("timeout",      16'(timeout),      16'(m_to));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"},   16'(state),        16'h0000);
        chk({tag, "_cnt_en"},  16'(cnt_en),       16'h0000);
        chk({tag, "_cnt_clr"}, 16'(cnt_clr),      16'h0000);
        chk({tag, "_result"},  result,            16'h0000);
        chk({tag, "_rv"},      16'(result_valid), 16'h0000);
        chk({tag, "_best"},    best,              16'h9999);
        chk({tag, "_bv"},      16'(best_valid),   16'h0000);
        chk({tag, "_foul"},    16'(foul),         16'h0000);
        chk({tag, "_timeout"}, 16'(timeout),      16'h0000);
    endtask

    // mode: 0 press at cnt, 1 false start at tick 500, 2 timeout,
    //       3 press together with 9999, 4 press on the expiry tick
    typedef struct {
        int          mode;
        logic [15:0] cnt;
        logic [2:0]  exp_state;
        logic [15:0] exp_result;
        bit          exp_rv;
        logic [15:0] exp_best;
        bit          exp_foul;
        bit          exp_to;
    } trial_t;

    trial_t tv[8];

    task automatic run_trial(input int idx, input trial_t t);
        int n;
        bit saw_en;
        string tag;
        tag = $sformatf("trial%0d", idx);
        btn = 1'b1; tick_1ms = 1'b0; cycle(); btn = 1'b0;
        chk({tag, "_armed"}, 16'(state), 16'h0001);
        chk({tag, "_clr"},   16'(cnt_clr), 16'h0001);
        saw_en = 0;
        n = 0;
        case (t.mode)
            1: begin
                tick_1ms = 1'b1;
                while (n < 500) begin cycle(); saw_en |= cnt_en; n++; end
                btn = 1'b1; tick_1ms = 1'b0; cycle(); btn = 1'b0;
                saw_en |= cnt_en;
                chk({tag, "_no_en"}, 16'(saw_en), 16'h0000);
            end
            4: begin
                tick_1ms = 1'b1;
                while (m_ticks < m_target - 1 && n < 3000) begin cycle(); n++; end
                btn = 1'b1; cycle(); btn = 1'b0; tick_1ms = 1'b0;
            end
            default: begin
                tick_1ms = 1'b1;
                while (state !== 3'd2 && n < 3000) begin cycle(); n++; end
                chk({tag, "_delay_ticks"}, 16'(n), 16'(m_target));
                tick_1ms = 1'b0;
                count_in = 16'h0001; cycle();
                chk({tag, "_cnt_en"}, 16'(cnt_en), 16'h0001);
                if (t.mode == 0) begin
                    count_in = t.cnt; btn = 1'b1; cycle(); btn = 1'b0;
                end else if (t.mode == 2) begin
                    count_in = 16'h9999; cycle();
                end else begin
                    count_in = 16'h9999; btn = 1'b1; cycle(); btn = 1'b0;
                end
                chk({tag, "_en_off"}, 16'(cnt_en), 16'h0000);
            end
        endcase
        count_in = 16'h0000; cycle();
        chk({tag, "_state"},   16'(state),        16'(t.exp_state));
        chk({tag, "_result"},  result,            t.exp_result);
        chk({tag, "_rv"},      16'(result_valid), 16'(t.exp_rv));
        chk({tag, "_best"},    best,              t.exp_best);
        chk({tag, "_foul"},    16'(foul),         16'(t.exp_foul));
        chk({tag, "_timeout"}, 16'(timeout),      16'(t.exp_to));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tv[0] = '{0, 16'h0250, 3'd3, 16'h0250, 1'b1, 16'h0250, 1'b0, 1'b0};
        tv[1] = '{1, 16'h0000, 3'd4, 16'h0250, 1'b1, 16'h0250, 1'b1, 1'b0};
        tv[2] = '{0, 16'h0310, 3'd3, 16'h0310, 1'b1, 16'h0250, 1'b0, 1'b0};
        tv[3] = '{0, 16'h0205, 3'd3, 16'h0205, 1'b1, 16'h0205, 1'b0, 1'b0};
        tv[4] = '{0, 16'h0400, 3'd3, 16'h0400, 1'b1, 16'h0205, 1'b0, 1'b0};
        tv[5] = '{2, 16'h0000, 3'd5, 16'h0400, 1'b1, 16'h0205, 1'b0, 1'b1};
        tv[6] = '{4, 16'h0000, 3'd4, 16'h0400, 1'b1, 16'h0205, 1'b1, 1'b0};
        tv[7] = '{3, 16'h0000, 3'd3, 16'h9999, 1'b1, 16'h0205, 1'b0, 1'b0};

        reset = 1'b1; btn = 1'b0; tick_1ms = 1'b0; count_in = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        check_all();
        reset = 1'b0;
        repeat (3) cycle();

        for (int i = 0; i < 8; i++) begin
            run_trial(i, tv[i]);
        end

        // New trial from DONE clears flags and pulses the counter clear once.
        btn = 1'b1; cycle(); btn = 1'b0;
        chk("rearm_state",   16'(state),   16'h0001);
        chk("rearm_foul",    16'(foul),    16'h0000);
        chk("rearm_timeout", 16'(timeout), 16'h0000);
        chk("rearm_clr",     16'(cnt_clr), 16'h0001);
        cycle();
        chk("rearm_clr_off", 16'(cnt_clr), 16'h0000);

        // Asynchronous reset in the middle of COUNTING.
        tick_1ms = 1'b1; n = 0;
        while (state !== 3'd2 && n < 3000) begin cycle(); n++; end
        chk("midrst_reached_counting", 16'(state), 16'h0002);
        tick_1ms = 1'b0; count_in = 16'h0123; cycle();
        #2 reset = 1'b1;
        #1 model_reset();
        check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b0;
        repeat (5) cycle();
        chk("postrst_idle", 16'(state), 16'h0000);

        for (int i = 0; i < 25000; i++) begin
            tick_1ms = ($urandom_range(3) != 0);
            if ($urandom_range(1499) == 0) btn = ~btn;
            count_in = ($urandom_range(199) == 0) ? 16'h9999 : rand_bcd();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
